// File: rtl/gpio_input_conditioner_pkg.sv
`default_nettype none
// ==== gpio_input_conditioner_pkg : shared constants and command FSM encoding (rev 1.0) ====
package gpio_input_conditioner_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

  localparam int CMD_SEQ_MSB = 31;
  localparam int CMD_SEQ_LSB = 24;
  localparam int CMD_SW_LSB  = 0;
  localparam int CMD_SEQ_W   = CMD_SEQ_MSB - CMD_SEQ_LSB + 1;

  typedef enum logic [0:0] {
    CMD_IDLE = 1'b0,
    CMD_PEND = 1'b1
  } cmd_state_e;

endpackage
`default_nettype wire

// File: rtl/gpio_input_conditioner_debounce_cell.sv
`default_nettype none
// ==== debounce_cell : 2-flop synchroniser, debounce counter and rising-edge pulse (rev 1.0) ====
module debounce_cell
  import gpio_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;

  // The count only advances while the synchronised input disagrees with the stable level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      meta_q  <= raw;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule
`default_nettype wire

// File: rtl/gpio_input_conditioner.sv
`default_nettype none
// ==== gpio_input_conditioner : debounced buttons/switches and capture-command handshake (rev 1.0) ====
module gpio_input_conditioner
  import gpio_input_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = 5,
  parameter int NUM_SW          = 8,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [NUM_SW-1:0]  sw_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_SW-1:0]  sw_level,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [31:0]        cmd_data,
  output logic               cmd_overrun
);

  logic [NUM_SW-1:0] sw_rise_unused;

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_in[i]),
        .level(btn_level[i]),
        .rise (btn_press[i])
      );
    end

    for (genvar j = 0; j < NUM_SW; j++) begin : g_sw
      debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (sw_in[j]),
        .level(sw_level[j]),
        .rise (sw_rise_unused[j])
      );
    end
  endgenerate

  cmd_state_e           state_q, state_d;
  logic [CMD_SEQ_W-1:0] seq_q, seq_d;
  logic [31:0]          data_q, data_d;
  logic                 overrun_q, overrun_d;
  logic [31:0]          cmd_word;
  logic                 capture;

  // A press is taken when nothing is pending or the pending word leaves in the same cycle.
  always_comb begin
    cmd_word                          = '0;
    cmd_word[CMD_SEQ_MSB:CMD_SEQ_LSB] = seq_q;
    cmd_word[CMD_SW_LSB +: NUM_SW]    = sw_level;

    capture   = btn_press[0] & ((state_q == CMD_IDLE) | cmd_ready);
    state_d   = state_q;
    seq_d     = seq_q;
    data_d    = data_q;
    overrun_d = btn_press[0] & (state_q == CMD_PEND) & ~cmd_ready;

    if ((state_q == CMD_PEND) && cmd_ready) begin
      state_d = CMD_IDLE;
    end
    if (capture) begin
      state_d = CMD_PEND;
      data_d  = cmd_word;
      seq_d   = seq_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CMD_IDLE;
      seq_q     <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign cmd_valid   = (state_q == CMD_PEND);
  assign cmd_data    = data_q;
  assign cmd_overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_input_conditioner.sv
`default_nettype none
// ==== tb_gpio_input_conditioner : randomized self-checking bench with behavioural model (rev 1.0) ====
module tb_gpio_input_conditioner;

  localparam int NUM_BTN = 5;
  localparam int NUM_SW  = 8;
  localparam int DB      = 4;
  localparam int NIN     = NUM_BTN + NUM_SW;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_BTN-1:0] btn_in = '0;
  logic [NUM_SW-1:0]  sw_in = '0;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_SW-1:0]  sw_level;
  logic               cmd_valid;
  logic               cmd_ready = 1'b0;
  logic [31:0]        cmd_data;
  logic               cmd_overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  gpio_input_conditioner #(
    .NUM_BTN        (NUM_BTN),
    .NUM_SW         (NUM_SW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .sw_in      (sw_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .sw_level   (sw_level),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_overrun(cmd_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: a level flips once the last DB synchronised samples (pad delayed by two
  // edges) all disagree with it and all came after its previous flip.
  logic [NIN-1:0] hist[$];
  int             edge_n;
  int             last_flip[NIN];
  logic [NIN-1:0] m_lvl;
  logic [NIN-1:0] m_press;
  logic           m_valid;
  logic           m_overrun;
  logic [31:0]    m_data;
  logic [7:0]     m_seq;

  function automatic logic [NIN-1:0] samp(int j);
    if (j < 1 || j > hist.size()) return '0;
    return hist[j-1];
  endfunction

  task automatic model_clear();
    hist.delete();
    edge_n    = 0;
    for (int b = 0; b < NIN; b++) last_flip[b] = 0;
    m_lvl     = '0;
    m_press   = '0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    m_data    = '0;
    m_seq     = '0;
  endtask

  task automatic cycle();
    logic [NIN-1:0]    pads;
    logic [NIN-1:0]    s;
    logic              ready_pre;
    logic              press0_pre;
    logic [NUM_SW-1:0] sw_pre;
    bool_t:
    @(posedge clk);
    pads      = {sw_in, btn_in};
    ready_pre = cmd_ready;
    if (!rst_n) begin
      model_clear();
    end else begin
      edge_n++;
      hist.push_back(pads);
      press0_pre = m_press[0];
      sw_pre     = m_lvl[NIN-1:NUM_BTN];
      m_overrun  = 1'b0;
      if (press0_pre && m_valid && !ready_pre) begin
        m_overrun = 1'b1;
      end else if (press0_pre) begin
        m_data        = 32'(sw_pre);
        m_data[31:24] = m_seq;
        m_seq         = m_seq + 8'd1;
        m_valid       = 1'b1;
      end else if (ready_pre) begin
        m_valid = 1'b0;
      end
      m_press = '0;
      for (int b = 0; b < NIN; b++) begin
        bit all_diff;
        all_diff = (edge_n - DB + 1) > last_flip[b];
        for (int i = 0; i < DB; i++) begin
          s = samp(edge_n - 2 - i);
          if (s[b] == m_lvl[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_lvl[b]     = ~m_lvl[b];
          last_flip[b] = edge_n;
          if (m_lvl[b]) m_press[b] = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    btn_in    = '0;
    cmd_ready = 1'b0;
    model_clear();
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  task automatic press_btn0(output bit ok);
    ok        = 1'b0;
    btn_in[0] = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      cycle();
      if (m_press[0]) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL press_timeout: got no press within 20 cycles, expected one");
    end
  endtask

  task automatic test_reset();
    int lat;
    sw_in     = 8'hFF;
    btn_in    = '0;
    cmd_ready = 1'b0;
    rst_n     = 1'b0;
    model_clear();
    repeat (3) cycle();
    n_cmp++;
    if ({btn_level, btn_press, sw_level, cmd_valid, cmd_data, cmd_overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {btn_level, btn_press, sw_level, cmd_valid, cmd_data, cmd_overrun});
    end
    rst_n = 1'b1;
    lat   = -1;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      if (lat < 0 && sw_level === 8'hFF) lat = c;
      n_cmp++;
      if (sw_level !== m_lvl[NIN-1:NUM_BTN]) begin
        n_fail++;
        $display("FAIL reset_sw_level: got %h expected %h", sw_level, m_lvl[NIN-1:NUM_BTN]);
      end
      n_cmp++;
      if (cmd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid);
      end
    end
    n_cmp++;
    if (lat < 6 || lat > 7) begin
      n_fail++;
      $display("FAIL reset_sw_latency: got %0d expected 6..7", lat);
    end
  endtask

  task automatic test_bounce();
    int presses;
    int rise;
    btn_in[0] = 1'b1; cycle();
    btn_in[0] = 1'b0; cycle();
    btn_in[0] = 1'b1;
    presses = 0;
    rise    = -1;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      if (btn_press[0] === 1'b1) presses++;
      if (rise < 0 && btn_level[0] === 1'b1) rise = c;
      n_cmp++;
      if ({btn_level, btn_press} !== {m_lvl[NUM_BTN-1:0], m_press[NUM_BTN-1:0]}) begin
        n_fail++;
        $display("FAIL bounce_btn: got %h expected %h", {btn_level, btn_press},
                 {m_lvl[NUM_BTN-1:0], m_press[NUM_BTN-1:0]});
      end
    end
    n_cmp++;
    if (rise != 2 + DB) begin
      n_fail++;
      $display("FAIL bounce_latency: got %0d expected %0d", rise, 2 + DB);
    end
    cmd_ready = 1'b1;
    btn_in[0] = 1'b0;
    repeat (10) begin
      cycle();
      if (btn_press[0] === 1'b1) presses++;
    end
    cmd_ready = 1'b0;
    n_cmp++;
    if (presses != 1 || btn_level[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_press_count: got %0d presses level %b expected 1 presses level 0",
               presses, btn_level[0]);
    end
  endtask

  task automatic test_capture();
    bit ok;
    do_reset();
    sw_in     = 8'hA5;
    cmd_ready = 1'b0;
    repeat (8) cycle();
    press_btn0(ok);
    btn_in[0] = 1'b0;
    cycle();
    n_cmp++;
    if (cmd_valid !== 1'b1 || cmd_data !== 32'h000000A5) begin
      n_fail++;
      $display("FAIL capture_word: got valid %b data %h expected valid 1 data 000000a5",
               cmd_valid, cmd_data);
    end
    for (int c = 0; c < 20; c++) begin
      cycle();
      n_cmp++;
      if (cmd_valid !== 1'b1 || cmd_data !== 32'h000000A5) begin
        n_fail++;
        $display("FAIL capture_hold: got valid %b data %h expected valid 1 data 000000a5",
                 cmd_valid, cmd_data);
      end
    end
    cmd_ready = 1'b1;
    cycle();
    cmd_ready = 1'b0;
    n_cmp++;
    if (cmd_valid !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_accept: got valid %b expected 0", cmd_valid);
    end
  endtask

  task automatic test_overrun();
    logic [NUM_SW-1:0] sw_a, sw_b;
    logic [31:0]       first, second;
    int                ov;
    bit                ok;
    do_reset();
    sw_a      = NUM_SW'($urandom);
    sw_in     = sw_a;
    cmd_ready = 1'b0;
    repeat (8) cycle();
    press_btn0(ok);
    btn_in[0] = 1'b0;
    repeat (DB + 3) cycle();
    first = 32'(sw_a);
    n_cmp++;
    if (cmd_valid !== 1'b1 || cmd_data !== first) begin
      n_fail++;
      $display("FAIL overrun_first: got valid %b data %h expected valid 1 data %h",
               cmd_valid, cmd_data, first);
    end
    sw_b  = ~sw_a;
    sw_in = sw_b;
    repeat (8) cycle();
    ov = 0;
    press_btn0(ok);
    btn_in[0] = 1'b0;
    repeat (DB + 3) begin
      cycle();
      if (cmd_overrun === 1'b1) ov++;
    end
    n_cmp++;
    if (ov != 1) begin
      n_fail++;
      $display("FAIL overrun_pulse: got %0d pulses expected 1", ov);
    end
    n_cmp++;
    if (cmd_valid !== 1'b1 || cmd_data !== first) begin
      n_fail++;
      $display("FAIL overrun_data_kept: got data %h expected %h", cmd_data, first);
    end
    cmd_ready = 1'b1;
    cycle();
    cmd_ready = 1'b0;
    press_btn0(ok);
    btn_in[0] = 1'b0;
    cycle();
    second        = 32'(sw_b);
    second[31:24] = 8'h01;
    n_cmp++;
    if (cmd_valid !== 1'b1 || cmd_data !== second) begin
      n_fail++;
      $display("FAIL overrun_next_seq: got data %h expected %h", cmd_data, second);
    end
    repeat (DB + 2) cycle();
  endtask

  task automatic test_simultaneous();
    logic [NUM_SW-1:0] sw_c;
    logic [31:0]       want;
    int                ov;
    bit                ok;
    sw_c  = NUM_SW'($urandom);
    sw_in = sw_c;
    repeat (8) cycle();
    press_btn0(ok);
    btn_in[0] = 1'b0;
    cmd_ready = 1'b1;
    cycle();
    cmd_ready     = 1'b0;
    want          = 32'(sw_c);
    want[31:24]   = 8'h02;
    n_cmp++;
    if (cmd_valid !== 1'b1 || cmd_data !== want || cmd_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_word: got valid %b data %h ovr %b expected valid 1 data %h ovr 0",
               cmd_valid, cmd_data, cmd_overrun, want);
    end
    ov = 0;
    repeat (DB + 2) begin
      cycle();
      if (cmd_overrun === 1'b1) ov++;
    end
    n_cmp++;
    if (ov != 0 || cmd_data !== m_data) begin
      n_fail++;
      $display("FAIL simul_no_overrun: got %0d pulses data %h expected 0 pulses data %h",
               ov, cmd_data, m_data);
    end
    cmd_ready = 1'b1;
    cycle();
    cmd_ready = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    bit ok;
    do_reset();
    sw_in     = NUM_SW'($urandom);
    cmd_ready = 1'b1;
    repeat (8) cycle();
    for (int i = 0; i < 257; i++) begin
      press_btn0(ok);
      btn_in[0] = 1'b0;
      cycle();
      n_cmp++;
      if (cmd_valid !== 1'b1 || cmd_data[31:24] !== 8'(i) || cmd_data !== m_data) begin
        n_fail++;
        $display("FAIL wrap_seq[%0d]: got valid %b data %h expected seq %h data %h",
                 i, cmd_valid, cmd_data, 8'(i), m_data);
      end
      repeat (DB + 2) cycle();
    end
    cmd_ready = 1'b0;
    press_btn0(ok);
    btn_in[0] = 1'b0;
    cycle();
    n_cmp++;
    if (cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pending: got valid %b expected 1", cmd_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (cmd_valid !== 1'b0 || cmd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got valid %b data %h expected 0 0", cmd_valid, cmd_data);
    end
    model_clear();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int             hold[NIN];
    logic [NIN-1:0] pads;
    do_reset();
    pads = {sw_in, btn_in};
    for (int b = 0; b < NIN; b++) hold[b] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < NIN; b++) begin
        if (hold[b] == 0) begin
          pads[b] = 1'($urandom_range(0, 1));
          hold[b] = int'($urandom_range(1, 9));
        end else begin
          hold[b]--;
        end
      end
      {sw_in, btn_in} = pads;
      cmd_ready       = ($urandom_range(0, 2) == 0);
      cycle();
      n_cmp++;
      if ({btn_level, btn_press, sw_level, cmd_valid, cmd_data, cmd_overrun} !==
          {m_lvl[NUM_BTN-1:0], m_press[NUM_BTN-1:0], m_lvl[NIN-1:NUM_BTN],
           m_valid, m_data, m_overrun}) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h", c,
                 {btn_level, btn_press, sw_level, cmd_valid, cmd_data, cmd_overrun},
                 {m_lvl[NUM_BTN-1:0], m_press[NUM_BTN-1:0], m_lvl[NIN-1:NUM_BTN],
                  m_valid, m_data, m_overrun});
      end
    end
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_bounce();
    test_capture();
    test_overrun();
    test_simultaneous();
    test_wrap_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
